// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave register interface.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Bit counter must hold 0..FL+1.
  function automatic int unsigned cnt_width(input int unsigned fl);
    return $clog2(fl + 2);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser with rising/falling edge pulses on the synchronised level.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q,
  output logic RISE,
  output logic FALL
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], D};
      prev  <= chain[STAGES-1];
    end
  end

  assign Q    = chain[STAGES-1];
  assign RISE = Q & ~prev;
  assign FALL = ~Q & prev;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI slave register interface: R/W flag, address, data frames with write strobe and read handshake.
module spi_slave_regif
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter logic        CPOL        = 1'b0,
  parameter logic        CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  output logic              WR_VALID,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              RD_REQ,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic              FRAME_ERR,
  output logic              BUSY
);

  localparam int unsigned FL  = 1 + ADDR_W + DATA_W;
  localparam int unsigned CW  = cnt_width(FL);
  localparam int unsigned SRW = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int unsigned SW  = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_FL  = CW'(FL);
  localparam logic [CW-1:0] CNT_SAT = CW'(FL + 1);
  localparam logic [CW-1:0] CNT_HDR = CW'(1 + ADDR_W);
  localparam logic [SW-1:0] SETTLED = SW'(SYNC_STAGES);
  localparam logic          SAMPLE_RISE = ({CPOL, CPHA} == MODE0) || ({CPOL, CPHA} == MODE3);

  logic sclk_q, sclk_rise, sclk_fall;
  logic ss_q, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_q;

  state_t            state;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [SRW-1:0]    sr_in, sr_in_nx;
  logic [DATA_W-1:0] sr_out;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q, first_sh, armed;
  logic [1:0]        rd_pipe;
  logic [SW-1:0]     settle;
  logic              in_frame, sample_e, shift_e;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .CLK(CLK), .RST(RST), .D(SCLK), .Q(sclk_q), .RISE(sclk_rise), .FALL(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .CLK(CLK), .RST(RST), .D(SS), .Q(ss_q), .RISE(ss_rise), .FALL(ss_fall)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) mosi_sync <= '0;
    else      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  assign in_frame = (state != IDLE);
  assign sample_e = (sclk_rise | sclk_fall) & (sclk_q == SAMPLE_RISE);
  assign shift_e  = (sclk_rise | sclk_fall) & (sclk_q != SAMPLE_RISE);

  always_comb begin
    cnt_nx   = cnt;
    sr_in_nx = sr_in;
    if (in_frame && sample_e) begin
      sr_in_nx = {sr_in[SRW-2:0], mosi_q};
      if (cnt != CNT_SAT) cnt_nx = cnt + 1'b1;
    end
  end

  // A frame may only start once SS has been seen high after reset settles.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      sr_in     <= '0;
      sr_out    <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      first_sh  <= 1'b0;
      armed     <= 1'b0;
      rd_pipe   <= '0;
      settle    <= '0;
      WR_VALID  <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      RD_REQ    <= 1'b0;
      RD_ADDR   <= '0;
      FRAME_ERR <= 1'b0;
    end else begin
      WR_VALID  <= 1'b0;
      RD_REQ    <= 1'b0;
      FRAME_ERR <= 1'b0;
      rd_pipe   <= {rd_pipe[0], RD_REQ};
      cnt       <= cnt_nx;
      sr_in     <= sr_in_nx;
      if (settle != SETTLED) settle <= settle + 1'b1;
      else if (ss_q)         armed  <= 1'b1;

      case (state)
        IDLE: begin
          if (ss_fall && armed) begin
            cnt     <= '0;
            sr_in   <= '0;
            sr_out  <= '0;
            rw_q    <= 1'b0;
            rd_pipe <= '0;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (sample_e && cnt_nx == CNT_HDR) begin
            rw_q     <= sr_in_nx[ADDR_W];
            addr_q   <= sr_in_nx[ADDR_W-1:0];
            first_sh <= 1'b1;
            state    <= DATA;
            if (sr_in_nx[ADDR_W]) begin
              RD_REQ  <= 1'b1;
              RD_ADDR <= sr_in_nx[ADDR_W-1:0];
            end
          end
        end
        DATA: begin
          // The loaded MSB must survive the first shift edge so the master sees it first.
          if (rd_pipe[1]) begin
            sr_out <= RD_DATA;
          end else if (shift_e) begin
            if (first_sh) first_sh <= 1'b0;
            else          sr_out   <= sr_out << 1;
          end
        end
        default: state <= IDLE;
      endcase

      if (in_frame && ss_rise) begin
        state <= IDLE;
        if (cnt_nx != CNT_FL) begin
          FRAME_ERR <= 1'b1;
        end else if (!rw_q) begin
          WR_VALID <= 1'b1;
          WR_ADDR  <= addr_q;
          WR_DATA  <= sr_in_nx[DATA_W-1:0];
        end
      end
    end
  end

  assign MISO    = (state == DATA) && rw_q && sr_out[DATA_W-1];
  assign MISO_OE = ~ss_q;
  assign BUSY    = in_frame;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Scoreboard bench for spi_slave_regif: mode 0 8/8, mode 3 8/8 and mode 0 12/16 instances.
module tb_spi_slave_regif;

  localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_ERR = 2'd2;
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] sclk = 3'b010;
  logic [2:0] ss   = 3'b111;
  logic [2:0] mosi = 3'b000;
  logic [2:0] miso, miso_oe, busy;

  logic        wr_valid0, rd_req0, frame_err0;
  logic [7:0]  wr_addr0, wr_data0, rd_addr0;
  logic [7:0]  rd_data0 = '0;
  logic        wr_valid1, rd_req1, frame_err1;
  logic [7:0]  wr_addr1, wr_data1, rd_addr1;
  logic [7:0]  rd_data1 = '0;
  logic        wr_valid2, rd_req2, frame_err2;
  logic [11:0] wr_addr2, rd_addr2;
  logic [15:0] wr_data2;
  logic [15:0] rd_data2 = '0;
  logic [31:0] rv0, rv1, rv2;

  int n_tests = 0;
  int n_fail  = 0;
  ev_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  spi_slave_regif u_dut0 (
    .CLK(clk), .RST(rst), .SCLK(sclk[0]), .SS(ss[0]), .MOSI(mosi[0]),
    .MISO(miso[0]), .MISO_OE(miso_oe[0]), .WR_VALID(wr_valid0), .WR_ADDR(wr_addr0),
    .WR_DATA(wr_data0), .RD_REQ(rd_req0), .RD_ADDR(rd_addr0), .RD_DATA(rd_data0),
    .FRAME_ERR(frame_err0), .BUSY(busy[0])
  );

  spi_slave_regif #(.CPOL(1'b1), .CPHA(1'b1)) u_dut1 (
    .CLK(clk), .RST(rst), .SCLK(sclk[1]), .SS(ss[1]), .MOSI(mosi[1]),
    .MISO(miso[1]), .MISO_OE(miso_oe[1]), .WR_VALID(wr_valid1), .WR_ADDR(wr_addr1),
    .WR_DATA(wr_data1), .RD_REQ(rd_req1), .RD_ADDR(rd_addr1), .RD_DATA(rd_data1),
    .FRAME_ERR(frame_err1), .BUSY(busy[1])
  );

  spi_slave_regif #(.ADDR_W(12), .DATA_W(16)) u_dut2 (
    .CLK(clk), .RST(rst), .SCLK(sclk[2]), .SS(ss[2]), .MOSI(mosi[2]),
    .MISO(miso[2]), .MISO_OE(miso_oe[2]), .WR_VALID(wr_valid2), .WR_ADDR(wr_addr2),
    .WR_DATA(wr_data2), .RD_REQ(rd_req2), .RD_ADDR(rd_addr2), .RD_DATA(rd_data2),
    .FRAME_ERR(frame_err2), .BUSY(busy[2])
  );

  function automatic int aw_of(input int d); return (d == 2) ? 12 : 8; endfunction
  function automatic int dw_of(input int d); return (d == 2) ? 16 : 8; endfunction
  function automatic logic cpha_of(input int d); return (d == 1); endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void push_ev(input int d, input ev_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  task automatic sb_pop(input int d, input logic [1:0] kind, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rdata);
    ev_t e;
    bit  have;
    have = 1'b0;
    e    = '0;
    case (d)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    n_tests++;
    rdata = e.data;
    if (!have) begin
      n_fail++;
      $display("FAIL sb%0d unexpected event: kind %0d addr %h data %h, none expected", d, kind, addr, data);
    end else if (e.kind != kind || e.addr != addr || (kind == K_WR && e.data != data)) begin
      n_fail++;
      $display("FAIL sb%0d event: got kind %0d addr %h data %h expected kind %0d addr %h data %h",
               d, kind, addr, data, e.kind, e.addr, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (rd_req0) begin sb_pop(0, K_RD, 32'(rd_addr0), '0, rv0); rd_data0 = rv0[7:0]; end
      if (wr_valid0) sb_pop(0, K_WR, 32'(wr_addr0), 32'(wr_data0), rv0);
      if (frame_err0) sb_pop(0, K_ERR, '0, '0, rv0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (rd_req1) begin sb_pop(1, K_RD, 32'(rd_addr1), '0, rv1); rd_data1 = rv1[7:0]; end
      if (wr_valid1) sb_pop(1, K_WR, 32'(wr_addr1), 32'(wr_data1), rv1);
      if (frame_err1) sb_pop(1, K_ERR, '0, '0, rv1);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (rd_req2) begin sb_pop(2, K_RD, 32'(rd_addr2), '0, rv2); rd_data2 = rv2[15:0]; end
      if (wr_valid2) sb_pop(2, K_WR, 32'(wr_addr2), 32'(wr_data2), rv2);
      if (frame_err2) sb_pop(2, K_ERR, '0, '0, rv2);
    end
  end

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  // Master side: sends word[n-1:0] MSB first, captures MISO on the master's sample edges.
  task automatic spi_frame(input int d, input int n, input logic [63:0] word, input bit tight,
                           output logic [63:0] rx);
    rx = '0;
    @(negedge clk);
    ss[d] = 1'b0;
    if (!cpha_of(d)) mosi[d] = word[n-1];
    half();
    chk("busy_in_frame", 64'(busy[d]), 64'd1);
    chk("miso_oe_in_frame", 64'(miso_oe[d]), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (cpha_of(d)) begin
        sclk[d] = ~sclk[d];
        mosi[d] = word[n-1-i];
        half();
        rx = {rx[62:0], miso[d]};
        sclk[d] = ~sclk[d];
        if (tight && i == n - 1) ss[d] = 1'b1;
        else half();
      end else begin
        rx = {rx[62:0], miso[d]};
        sclk[d] = ~sclk[d];
        half();
        sclk[d] = ~sclk[d];
        if (i < n - 1) mosi[d] = word[n-2-i];
        half();
      end
    end
    ss[d] = 1'b1;
    repeat (20) @(negedge clk);
    mosi[d] = 1'b0;
  endtask

  // Reference model: frame contents and expected slave events from field values and length.
  task automatic run_frame(input int d, input logic rw, input int unsigned addr, input int unsigned data,
                           input int len, input bit tight, input int unsigned rdata);
    int aw, dw, fl;
    int unsigned am, dm, rm;
    logic [63:0] word, rx;
    ev_t e;
    aw = aw_of(d);
    dw = dw_of(d);
    fl = 1 + aw + dw;
    am = addr  & ((32'd1 << aw) - 1);
    dm = data  & ((32'd1 << dw) - 1);
    rm = rdata & ((32'd1 << dw) - 1);
    word = (64'(rw) << (aw + dw)) | (64'(am) << dw) | 64'(dm);
    if (len < fl) word = word >> (fl - len);
    else if (len > fl) word = (word << (len - fl)) | 64'($urandom_range(0, (1 << (len - fl)) - 1));
    if (rw && len >= 1 + aw) begin e.kind = K_RD; e.addr = am; e.data = rm; push_ev(d, e); end
    if (len == fl && !rw)    begin e.kind = K_WR; e.addr = am; e.data = dm; push_ev(d, e); end
    if (len != fl)           begin e.kind = K_ERR; e.addr = '0; e.data = '0; push_ev(d, e); end
    spi_frame(d, len, word, tight, rx);
    if (len == fl) chk($sformatf("miso_d%0d", d), rx, rw ? 64'(rm) : 64'd0);
    chk($sformatf("busy_after_d%0d", d), 64'(busy[d]), 64'd0);
  endtask

  initial begin
    int fl, len;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {61'd0, wr_valid0 | wr_valid1 | wr_valid2, rd_req0 | rd_req1 | rd_req2,
                        frame_err0 | frame_err1 | frame_err2}, 64'd0);
    chk("rst_pins", {55'd0, miso, miso_oe, busy}, 64'd0);
    chk("rst_regs0", {32'd0, wr_addr0, wr_data0, rd_addr0, 8'd0}, 64'd0);
    chk("rst_regs1", {32'd0, wr_addr1, wr_data1, rd_addr1, 8'd0}, 64'd0);
    chk("rst_regs2", {24'd0, wr_addr2, wr_data2, rd_addr2}, 64'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    run_frame(0, 1'b0, 32'h12, 32'hA5, 17, 1'b0, 0);
    run_frame(0, 1'b1, 32'h34, 0, 17, 1'b0, 32'h5C);
    run_frame(1, 1'b0, 32'hFF, 32'h00, 17, 1'b1, 0);
    run_frame(1, 1'b1, 32'h01, 0, 17, 1'b0, 32'h81);
    run_frame(0, 1'b0, 32'h55, 32'h66, 10, 1'b0, 0);
    run_frame(0, 1'b0, 32'h55, 32'h66, 20, 1'b0, 0);

    // SCLK activity with SS high must not start anything.
    for (int i = 0; i < 10; i++) begin
      sclk[0] = ~sclk[0];
      mosi[0] = 1'($urandom);
      half();
    end
    chk("idle_sclk_busy", 64'(busy[0]), 64'd0);

    // Reset mid-frame, release with SS still low, then finish clocking the stale frame.
    @(negedge clk);
    ss[0] = 1'b0;
    half();
    for (int i = 0; i < 12; i++) begin
      sclk[0] = ~sclk[0];
      mosi[0] = 1'($urandom);
      half();
    end
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy[0]), 64'd0);
    chk("midrst_oe", 64'(miso_oe[0]), 64'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 22; i++) begin
      sclk[0] = ~sclk[0];
      mosi[0] = 1'($urandom);
      half();
    end
    chk("stale_ss_busy", 64'(busy[0]), 64'd0);
    ss[0] = 1'b1;
    mosi[0] = 1'b0;
    repeat (20) @(negedge clk);
    run_frame(0, 1'b0, 32'h0A, 32'h3C, 17, 1'b0, 0);

    run_frame(2, 1'b0, 32'hABC, 32'hBEEF, 29, 1'b0, 0);

    for (int d = 0; d < 3; d++) begin
      fl = 1 + aw_of(d) + dw_of(d);
      for (int k = 0; k < 12; k++) begin
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, fl + 4) : fl;
        run_frame(d, 1'($urandom), $urandom, $urandom, len, (d == 1) && ($urandom_range(0, 1) == 1),
                  $urandom);
      end
    end

    repeat (40) @(negedge clk);
    chk("sb0_pending", 64'(q0.size()), 64'd0);
    chk("sb1_pending", 64'(q1.size()), 64'd0);
    chk("sb2_pending", 64'(q2.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
